// File: rtl/ifetch_step_unit.sv
// Instruction-fetch front end: holds the PC, fetches one word at a time from a
// handshaked instruction memory, and offers it to the CPU. It either free-runs
// or, in single-step mode, lets each debounced press of key_ok release one fetch.
//
// Handshake rules (both interfaces):
//   - imem: imem_req rises and stays high, with imem_addr stable, until the
//     cycle in which imem_ack=1. imem_rdata is only looked at in that cycle.
//   - CPU:  instr_valid stays high and instr_out/pc_out stay frozen until the
//     edge at which instr_valid & instr_ready are both 1. That edge is the
//     transfer; instr_valid drops after it.
module ifetch_step_unit #(
  parameter int              PC_W       = 16,
  parameter int              INSTR_W    = 32,
  parameter int              DEB_CYCLES = 4,
  parameter logic [PC_W-1:0] RESET_PC   = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               key_ok,
  input  logic               run_mode,
  input  logic               load_pc,
  input  logic [PC_W-1:0]    data_in,
  input  logic               branch_take,
  input  logic [PC_W-1:0]    offset,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr_out,
  output logic [PC_W-1:0]    pc_out,
  output logic [1:0]         dbg_state
);

  typedef enum logic [1:0] {
    WAIT_STEP = 2'd0,
    REQ       = 2'd1,
    HOLD      = 2'd2
  } state_t;

  localparam int             CNT_W    = $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  state_t            state;
  state_t            state_n;
  logic [PC_W-1:0]   pc;
  logic [PC_W-1:0]   next_pc;
  logic              sync1;
  logic              sync2;
  logic              filt;
  logic [CNT_W-1:0]  deb_cnt;
  logic              step_pulse;
  logic              capture;
  logic              consume;

  // Synchronise key_ok, accept a level change only after DEB_CYCLES
  // consecutive differing samples, and pulse once on each accepted press.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1      <= 1'b1;
      sync2      <= 1'b1;
      filt       <= 1'b1;
      deb_cnt    <= '0;
      step_pulse <= 1'b0;
    end else begin
      sync1      <= key_ok;
      sync2      <= sync1;
      step_pulse <= 1'b0;
      if (sync2 != filt) begin
        if (deb_cnt == CNT_LAST) begin
          filt       <= sync2;
          deb_cnt    <= '0;
          // Key is active-low: only the 1->0 acceptance is a press.
          step_pulse <= ~sync2;
        end else begin
          deb_cnt <= deb_cnt + 1'b1;
        end
      end else begin
        deb_cnt <= '0;
      end
    end
  end

  assign capture = (state == REQ) && imem_ack;
  assign consume = (state == HOLD) && instr_valid && instr_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= WAIT_STEP;
    end else begin
      state <= state_n;
    end
  end

  // Next-state logic; step pulses seen outside WAIT_STEP are simply dropped.
  always_comb begin
    state_n = state;
    case (state)
      WAIT_STEP: if (run_mode || step_pulse) state_n = REQ;
      REQ:       if (imem_ack)               state_n = HOLD;
      HOLD:      if (consume)                state_n = run_mode ? REQ : WAIT_STEP;
      default:                               state_n = WAIT_STEP;
    endcase
  end

  // Next PC on consume: absolute load beats branch beats sequential.
  always_comb begin
    next_pc = pc_out + 1'b1;
    if (load_pc) begin
      next_pc = data_in;
    end else if (branch_take) begin
      next_pc = pc_out + 1'b1 + offset;
    end
  end

  // PC and CPU-side output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc          <= RESET_PC;
      instr_valid <= 1'b0;
      instr_out   <= '0;
      pc_out      <= RESET_PC;
    end else begin
      // A load while parked takes effect before the fetch it launches.
      if ((state == WAIT_STEP) && load_pc) begin
        pc <= data_in;
      end
      if (capture) begin
        instr_out   <= imem_rdata;
        pc_out      <= pc;
        instr_valid <= 1'b1;
      end
      if (consume) begin
        pc          <= next_pc;
        instr_valid <= 1'b0;
      end
    end
  end

  assign imem_req  = (state == REQ);
  assign imem_addr = pc;
  assign dbg_state = state;

endmodule
